// File: rtl/pipeline_pkg.sv
// Shared pipeline widths and ALU operation encodings used by the decode/execute boundary.
package pipeline_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned BUBBLE_W   = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    AluAdd  = 4'h0,
    AluSub  = 4'h1,
    AluAnd  = 4'h2,
    AluOr   = 4'h3,
    AluXor  = 4'h4,
    AluSll  = 4'h5,
    AluSrl  = 4'h6,
    AluSra  = 4'h7,
    AluSlt  = 4'h8,
    AluSltu = 4'h9,
    AluLui  = 4'hA
  } alu_op_e;

  // True when a nonzero destination feeds either source of the instruction in decode.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] r,
                                     input logic [REG_ADDR_W-1:0] rs1,
                                     input logic [REG_ADDR_W-1:0] rs2);
    return (r != '0) && ((r == rs1) || (r == rs2));
  endfunction

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard detection: a load in EX or MEM whose result the decoding instruction needs.
module load_use_detector
  import pipeline_pkg::*;
(
  input  logic                  IF_ID_valid,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_EX_valid,
  input  logic                  ID_EX_memread,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  input  logic                  EX_MEM_regwrite,
  input  logic                  EX_MEM_memread,
  input  logic                  EX_branch_taken,
  output logic                  stall
);

  logic haz_ex;
  logic haz_mem;

  // Both sources are checked regardless of whether the opcode actually reads rs2.
  always_comb begin
    haz_ex  = ID_EX_valid && ID_EX_memread && src_match(ID_EX_rd, ID_rs1, ID_rs2);
    // Load data is not forwardable out of EX/MEM, so wait one more cycle for MEM/WB.
    haz_mem = EX_MEM_memread && EX_MEM_regwrite && src_match(EX_MEM_rd, ID_rs1, ID_rs2);
    stall   = IF_ID_valid && (haz_ex || haz_mem) && !EX_branch_taken;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding select, load-use stall and bubble counting.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  IF_ID_valid,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic [REG_ADDR_W-1:0] ID_rd,
  input  logic [XLEN-1:0]       ID_rs1_rf_data,
  input  logic [XLEN-1:0]       ID_rs2_rf_data,
  input  logic [XLEN-1:0]       ID_imm,
  input  logic [XLEN-1:0]       ID_pc,

  input  logic                  ID_regwrite,
  input  logic                  ID_memread,
  input  logic                  ID_memwrite,
  input  logic                  ID_alu_src,
  input  logic [ALU_OP_W-1:0]   ID_alu_op,

  input  logic                  ID_hazard_rs1_data_enable,
  input  logic [XLEN-1:0]       ID_hazard_rs1_data,
  input  logic                  ID_hazard_rs2_data_enable,
  input  logic [XLEN-1:0]       ID_hazard_rs2_data,

  input  logic [REG_ADDR_W-1:0] EX_MEM_rd,
  input  logic                  EX_MEM_regwrite,
  input  logic                  EX_MEM_memread,
  input  logic                  EX_branch_taken,

  output logic                  ID_stall,
  output logic                  ID_EX_valid,
  output logic [XLEN-1:0]       ID_EX_rs1_data,
  output logic [XLEN-1:0]       ID_EX_rs2_data,
  output logic [XLEN-1:0]       ID_EX_imm,
  output logic [XLEN-1:0]       ID_EX_pc,
  output logic [REG_ADDR_W-1:0] ID_EX_rs1,
  output logic [REG_ADDR_W-1:0] ID_EX_rs2,
  output logic [REG_ADDR_W-1:0] ID_EX_rd,
  output logic                  ID_EX_regwrite,
  output logic                  ID_EX_memread,
  output logic                  ID_EX_memwrite,
  output logic                  ID_EX_alu_src,
  output logic [ALU_OP_W-1:0]   ID_EX_alu_op,
  output logic [BUBBLE_W-1:0]   bubble_count
);

  logic [XLEN-1:0] rs1_op;
  logic [XLEN-1:0] rs2_op;
  logic            det_stall;

  always_comb begin
    rs1_op = ID_hazard_rs1_data_enable ? ID_hazard_rs1_data : ID_rs1_rf_data;
    rs2_op = ID_hazard_rs2_data_enable ? ID_hazard_rs2_data : ID_rs2_rf_data;
  end

  load_use_detector u_detector (
    .IF_ID_valid     (IF_ID_valid),
    .ID_rs1          (ID_rs1),
    .ID_rs2          (ID_rs2),
    .ID_EX_valid     (ID_EX_valid),
    .ID_EX_memread   (ID_EX_memread),
    .ID_EX_rd        (ID_EX_rd),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_regwrite (EX_MEM_regwrite),
    .EX_MEM_memread  (EX_MEM_memread),
    .EX_branch_taken (EX_branch_taken),
    .stall           (det_stall)
  );

  // Reset masks the stall so the front end is never frozen while held in reset.
  assign ID_stall = rst_n && det_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ID_EX_valid    <= 1'b0;
      ID_EX_rs1_data <= '0;
      ID_EX_rs2_data <= '0;
      ID_EX_imm      <= '0;
      ID_EX_pc       <= '0;
      ID_EX_rs1      <= '0;
      ID_EX_rs2      <= '0;
      ID_EX_rd       <= '0;
      ID_EX_regwrite <= 1'b0;
      ID_EX_memread  <= 1'b0;
      ID_EX_memwrite <= 1'b0;
      ID_EX_alu_src  <= 1'b0;
      ID_EX_alu_op   <= '0;
      bubble_count   <= '0;
    end else if (EX_branch_taken) begin
      // Flush bubble: datapath fields hold, not counted.
      ID_EX_valid    <= 1'b0;
      ID_EX_regwrite <= 1'b0;
      ID_EX_memread  <= 1'b0;
      ID_EX_memwrite <= 1'b0;
    end else if (ID_stall) begin
      ID_EX_valid    <= 1'b0;
      ID_EX_regwrite <= 1'b0;
      ID_EX_memread  <= 1'b0;
      ID_EX_memwrite <= 1'b0;
      if (bubble_count != {BUBBLE_W{1'b1}}) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end else begin
      ID_EX_valid    <= IF_ID_valid;
      ID_EX_rs1_data <= rs1_op;
      ID_EX_rs2_data <= rs2_op;
      ID_EX_imm      <= ID_imm;
      ID_EX_pc       <= ID_pc;
      ID_EX_rs1      <= ID_rs1;
      ID_EX_rs2      <= ID_rs2;
      ID_EX_rd       <= ID_rd;
      ID_EX_regwrite <= IF_ID_valid && ID_regwrite;
      ID_EX_memread  <= IF_ID_valid && ID_memread;
      ID_EX_memwrite <= IF_ID_valid && ID_memwrite;
      ID_EX_alu_src  <= IF_ID_valid && ID_alu_src;
      ID_EX_alu_op   <= IF_ID_valid ? ID_alu_op : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: latency, forwarding select, load-use stalls, flush, reset.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IF_ID_valid;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic [31:0] ID_rs1_rf_data, ID_rs2_rf_data, ID_imm, ID_pc;
  logic        ID_regwrite, ID_memread, ID_memwrite, ID_alu_src;
  logic [3:0]  ID_alu_op;
  logic        ID_hazard_rs1_data_enable, ID_hazard_rs2_data_enable;
  logic [31:0] ID_hazard_rs1_data, ID_hazard_rs2_data;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_regwrite, EX_MEM_memread, EX_branch_taken;

  logic        ID_stall, ID_EX_valid;
  logic [31:0] ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic        ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_alu_src;
  logic [3:0]  ID_EX_alu_op;
  logic [15:0] bubble_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .IF_ID_valid               (IF_ID_valid),
    .ID_rs1                    (ID_rs1),
    .ID_rs2                    (ID_rs2),
    .ID_rd                     (ID_rd),
    .ID_rs1_rf_data            (ID_rs1_rf_data),
    .ID_rs2_rf_data            (ID_rs2_rf_data),
    .ID_imm                    (ID_imm),
    .ID_pc                     (ID_pc),
    .ID_regwrite               (ID_regwrite),
    .ID_memread                (ID_memread),
    .ID_memwrite               (ID_memwrite),
    .ID_alu_src                (ID_alu_src),
    .ID_alu_op                 (ID_alu_op),
    .ID_hazard_rs1_data_enable (ID_hazard_rs1_data_enable),
    .ID_hazard_rs1_data        (ID_hazard_rs1_data),
    .ID_hazard_rs2_data_enable (ID_hazard_rs2_data_enable),
    .ID_hazard_rs2_data        (ID_hazard_rs2_data),
    .EX_MEM_rd                 (EX_MEM_rd),
    .EX_MEM_regwrite           (EX_MEM_regwrite),
    .EX_MEM_memread            (EX_MEM_memread),
    .EX_branch_taken           (EX_branch_taken),
    .ID_stall                  (ID_stall),
    .ID_EX_valid               (ID_EX_valid),
    .ID_EX_rs1_data            (ID_EX_rs1_data),
    .ID_EX_rs2_data            (ID_EX_rs2_data),
    .ID_EX_imm                 (ID_EX_imm),
    .ID_EX_pc                  (ID_EX_pc),
    .ID_EX_rs1                 (ID_EX_rs1),
    .ID_EX_rs2                 (ID_EX_rs2),
    .ID_EX_rd                  (ID_EX_rd),
    .ID_EX_regwrite            (ID_EX_regwrite),
    .ID_EX_memread             (ID_EX_memread),
    .ID_EX_memwrite            (ID_EX_memwrite),
    .ID_EX_alu_src             (ID_EX_alu_src),
    .ID_EX_alu_op              (ID_EX_alu_op),
    .bubble_count              (bubble_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a valid instruction in decode with no forwarding.
  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] pc, input logic mr, input logic rw);
    IF_ID_valid = 1'b1;
    ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd; ID_pc = pc;
    ID_memread = mr; ID_regwrite = rw; ID_memwrite = 1'b0;
    ID_alu_src = mr; ID_alu_op = AluAdd;
    ID_hazard_rs1_data_enable = 1'b0; ID_hazard_rs2_data_enable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; IF_ID_valid = 1'b0;
    ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0;
    ID_rs1_rf_data = '0; ID_rs2_rf_data = '0; ID_imm = '0; ID_pc = '0;
    ID_regwrite = 1'b0; ID_memread = 1'b0; ID_memwrite = 1'b0; ID_alu_src = 1'b0;
    ID_alu_op = '0;
    ID_hazard_rs1_data_enable = 1'b0; ID_hazard_rs1_data = '0;
    ID_hazard_rs2_data_enable = 1'b0; ID_hazard_rs2_data = '0;
    EX_MEM_rd = '0; EX_MEM_regwrite = 1'b0; EX_MEM_memread = 1'b0; EX_branch_taken = 1'b0;

    // Reset state, and stall masked while in reset even with a MEM hazard present.
    tick();
    check("rst_valid", {31'd0, ID_EX_valid}, 32'd0);
    check("rst_pc", ID_EX_pc, 32'd0);
    check("rst_count", {16'd0, bubble_count}, 32'd0);
    set_instr(5'd3, 5'd0, 5'd1, 32'h4, 1'b0, 1'b1);
    EX_MEM_rd = 5'd3; EX_MEM_memread = 1'b1; EX_MEM_regwrite = 1'b1;
    #1;
    check("rst_no_stall", {31'd0, ID_stall}, 32'd0);
    EX_MEM_memread = 1'b0; EX_MEM_regwrite = 1'b0; EX_MEM_rd = '0;

    // lw x5, 1-cycle latency.
    rst_n = 1'b1;
    set_instr(5'd1, 5'd0, 5'd5, 32'h10, 1'b1, 1'b1);
    ID_rs1_rf_data = 32'h1000; ID_imm = 32'h8;
    tick();
    check("lw_valid", {31'd0, ID_EX_valid}, 32'd1);
    check("lw_memread", {31'd0, ID_EX_memread}, 32'd1);
    check("lw_rd", {27'd0, ID_EX_rd}, 32'd5);
    check("lw_pc", ID_EX_pc, 32'h10);
    check("lw_rs1_data", ID_EX_rs1_data, 32'h1000);
    check("lw_imm", ID_EX_imm, 32'h8);

    // Dependent instruction: hazEX stall then hazMEM stall, then issue with forwarded data.
    set_instr(5'd5, 5'd2, 5'd6, 32'h14, 1'b0, 1'b1);
    #1;
    check("dep_stall1", {31'd0, ID_stall}, 32'd1);
    tick();
    check("dep_bubble1_valid", {31'd0, ID_EX_valid}, 32'd0);
    check("dep_bubble1_rw", {31'd0, ID_EX_regwrite}, 32'd0);
    check("dep_count1", {16'd0, bubble_count}, 32'd1);
    EX_MEM_rd = 5'd5; EX_MEM_memread = 1'b1; EX_MEM_regwrite = 1'b1;
    #1;
    check("dep_stall2", {31'd0, ID_stall}, 32'd1);
    tick();
    check("dep_count2", {16'd0, bubble_count}, 32'd2);
    EX_MEM_memread = 1'b0; EX_MEM_regwrite = 1'b0; EX_MEM_rd = '0;
    ID_hazard_rs1_data_enable = 1'b1; ID_hazard_rs1_data = 32'hCAFE0001;
    #1;
    check("dep_stall_clear", {31'd0, ID_stall}, 32'd0);
    tick();
    check("dep_issue_valid", {31'd0, ID_EX_valid}, 32'd1);
    check("dep_issue_pc", ID_EX_pc, 32'h14);
    check("dep_issue_fwd", ID_EX_rs1_data, 32'hCAFE0001);
    check("dep_issue_rw", {31'd0, ID_EX_regwrite}, 32'd1);
    check("dep_count_hold", {16'd0, bubble_count}, 32'd2);

    // rs2 forwarding overrides the regfile value.
    set_instr(5'd2, 5'd7, 5'd8, 32'h18, 1'b0, 1'b1);
    ID_rs2_rf_data = 32'h0;
    ID_hazard_rs2_data_enable = 1'b1; ID_hazard_rs2_data = 32'hDEADBEEF;
    tick();
    check("fwd_rs2", ID_EX_rs2_data, 32'hDEADBEEF);
    check("fwd_rs2_idx", {27'd0, ID_EX_rs2}, 32'd7);

    // EX/MEM non-load writer and load without regwrite must not stall.
    set_instr(5'd4, 5'd0, 5'd9, 32'h1C, 1'b0, 1'b1);
    EX_MEM_rd = 5'd4; EX_MEM_regwrite = 1'b1; EX_MEM_memread = 1'b0;
    #1;
    check("mem_alu_no_stall", {31'd0, ID_stall}, 32'd0);
    EX_MEM_regwrite = 1'b0; EX_MEM_memread = 1'b1;
    #1;
    check("mem_norw_no_stall", {31'd0, ID_stall}, 32'd0);
    EX_MEM_memread = 1'b0; EX_MEM_rd = '0;

    // Load to x0 then consumer of x0: no stall.
    set_instr(5'd1, 5'd0, 5'd0, 32'h20, 1'b1, 1'b1);
    tick();
    set_instr(5'd0, 5'd0, 5'd3, 32'h24, 1'b0, 1'b1);
    #1;
    check("x0_no_stall", {31'd0, ID_stall}, 32'd0);
    tick();

    // hazEX with branch flush: no stall, bubble, count unchanged.
    set_instr(5'd1, 5'd0, 5'd9, 32'h28, 1'b1, 1'b1);
    tick();
    set_instr(5'd3, 5'd9, 5'd10, 32'h2C, 1'b0, 1'b1);
    #1;
    check("rs2_haz_stall", {31'd0, ID_stall}, 32'd1);
    EX_branch_taken = 1'b1;
    #1;
    check("flush_no_stall", {31'd0, ID_stall}, 32'd0);
    tick();
    EX_branch_taken = 1'b0;
    check("flush_valid", {31'd0, ID_EX_valid}, 32'd0);
    check("flush_memread", {31'd0, ID_EX_memread}, 32'd0);
    check("flush_count", {16'd0, bubble_count}, 32'd2);

    // Invalid decode slot forces control bits off.
    set_instr(5'd1, 5'd2, 5'd11, 32'h30, 1'b1, 1'b1);
    IF_ID_valid = 1'b0; ID_memwrite = 1'b1;
    tick();
    check("inval_valid", {31'd0, ID_EX_valid}, 32'd0);
    check("inval_ctl", {28'd0, ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_alu_src},
          32'd0);

    // Reset in the middle of a stall.
    set_instr(5'd1, 5'd0, 5'd5, 32'h34, 1'b1, 1'b1);
    tick();
    set_instr(5'd5, 5'd0, 5'd6, 32'h38, 1'b0, 1'b1);
    tick();
    check("pre_rst_count", {16'd0, bubble_count}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, ID_stall}, 32'd0);
    tick();
    check("rst2_valid", {31'd0, ID_EX_valid}, 32'd0);
    check("rst2_count", {16'd0, bubble_count}, 32'd0);
    check("rst2_rd", {27'd0, ID_EX_rd}, 32'd0);
    check("rst2_pc", ID_EX_pc, 32'd0);
    rst_n = 1'b1;
    set_instr(5'd5, 5'd0, 5'd6, 32'h100, 1'b0, 1'b1);
    tick();
    check("post_rst_pc", ID_EX_pc, 32'h100);
    check("post_rst_valid", {31'd0, ID_EX_valid}, 32'd1);

    // Saturation: hold a MEM load-use hazard for 65535 stalls, then one more.
    set_instr(5'd4, 5'd0, 5'd12, 32'h104, 1'b0, 1'b1);
    EX_MEM_rd = 5'd4; EX_MEM_regwrite = 1'b1; EX_MEM_memread = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("sat_reach", {16'd0, bubble_count}, 32'hFFFF);
    tick();
    check("sat_hold", {16'd0, bubble_count}, 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: ID_EX_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL have inputs: IF_ID_valid 1 ID holds real instr; ID_rs1, ID_rs2, ID_rd 5 each; ID_rs1_rf_data, ID_rs2_rf_data 32 each, regfile reads; ID_imm 32; ID_pc 32.
REQ-003 SHALL have control inputs: ID_regwrite 1, ID_memread 1, ID_memwrite 1, ID_alu_src 1, ID_alu_op 4.
REQ-004 SHALL have forwarding inputs: ID_hazard_rs1_data_enable 1, ID_hazard_rs1_data 32, ID_hazard_rs2_data_enable 1, ID_hazard_rs2_data 32.
REQ-005 SHALL have EX/MEM inputs: EX_MEM_rd 5, EX_MEM_regwrite 1, EX_MEM_memread 1; plus EX_branch_taken 1, flush request from EX.
REQ-006 SHALL have outputs: ID_stall 1, freezes PC and IF/ID when high; ID_EX_valid 1; ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm, ID_EX_pc 32 each; ID_EX_rs1, ID_EX_rs2, ID_EX_rd 5 each.
REQ-007 SHALL have registered control outputs ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_alu_src 1 each, ID_EX_alu_op 4, and bubble_count 16.

Function
REQ-008 Operand select SHALL be combinational: rsN_op = ID_hazard_rsN_data_enable ? ID_hazard_rsN_data : ID_rsN_rf_data.
REQ-009 match(r) SHALL be r != 0 && (r == ID_rs1 || r == ID_rs2); both sources checked for every instruction (conservative).
REQ-010 hazEX SHALL be ID_EX_valid && ID_EX_memread && match(ID_EX_rd).
REQ-011 hazMEM SHALL be EX_MEM_memread && EX_MEM_regwrite && match(EX_MEM_rd), since load results are not forwardable from EX/MEM.
REQ-012 ID_stall SHALL be combinational: IF_ID_valid && (hazEX || hazMEM) && !EX_branch_taken.
REQ-013 Each rising edge, priority: rst_n low > EX_branch_taken > ID_stall > load.
REQ-014 Flush SHALL load a bubble: ID_EX_valid, regwrite, memread, memwrite = 0; other fields don't-care, held.
REQ-015 Stall SHALL load a bubble as REQ-014 and increment bubble_count.
REQ-016 Load SHALL capture all ID_* fields, rsN_op into ID_EX_rsN_data, and ID_EX_valid = IF_ID_valid; with IF_ID_valid low, control bits SHALL be forced 0.
REQ-017 Latency ID to ID_EX SHALL be exactly 1 cycle.
REQ-018 Load immediately followed by dependent instr SHALL stall 2 cycles (hazEX, then hazMEM), then issue with MEM_WB forwarded data.
REQ-019 bubble_count SHALL saturate at 0xFFFF, never wrap; flush bubbles SHALL NOT count.
REQ-020 Flush and stall in the same cycle: flush wins, ID_stall = 0, count unchanged.

Reset
REQ-021 On rising clk with rst_n low, all ID_EX_* outputs and bubble_count SHALL be 0.
REQ-022 ID_stall SHALL be 0 while rst_n low; reset mid-stall aborts the stall, first post-reset edge loads normally.

Structure
REQ-023 XLEN=32, REG_ADDR_W=5, ALU_OP_W=4 and ALU op encodings SHALL live in shared package pipeline_pkg.
REQ-024 Hazard terms REQ-009..REQ-012 SHALL be a sub-module load_use_detector; registers and muxes stay in ID_EX_stage.

Verification
REQ-025 lw x5 in ID_EX, ID_rs1=5, IF_ID_valid=1 -> ID_stall=1 two cycles, two bubbles, bubble_count=2, third edge loads instr.
REQ-026 ID_hazard_rs2_data_enable=1, data 0xDEADBEEF, rf 0x0 -> ID_EX_rs2_data=0xDEADBEEF one edge later.
REQ-027 hazEX with EX_branch_taken=1 -> ID_stall=0, ID_EX_valid=0, bubble_count unchanged.
REQ-028 Load to x0, ID_rs1=0 -> no stall.
REQ-029 bubble_count preset to 0xFFFF by 65535 stalls, one more stall -> stays 0xFFFF.
REQ-030 rst_n low for one edge mid-stall -> all outputs 0; next edge with no hazard loads ID_pc=0x100 into ID_EX_pc.
